// File: rtl/soc_system_frame_writer_if.sv
// Pixel-stream sink and memory-port bundles for soc_system_frame_writer.
// master drives the transfer and slave receives it.
interface frame_st_if;
    logic [7:0] data;
    logic       valid;
    logic       sop;
    logic       eop;
    logic       ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

interface frame_mem_if;
    logic [15:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        clken;

    modport master (output address, byteenable, chipselect, write, writedata, clken);
    modport slave  (input address, byteenable, chipselect, write, writedata, clken);
endinterface

// File: rtl/soc_system_frame_writer.sv
// Packs an 8-bit pixel stream four-per-word and writes each armed frame into memory port s2.
// Define FRAME_WRITER_DBL_BUF_EN to alternate frames between two buffers.
module soc_system_frame_writer #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned FRAME_WORDS = 19200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count,
    output logic        buf_sel,
    frame_st_if.slave   snk,
    frame_mem_if.master mem
);
    localparam logic [15:0] FW = 16'(FRAME_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOP,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]  lane_q;     // lanes already filled in the word being packed
    logic [23:0] pack_q;
    logic        flush_q;
    logic [15:0] base_cur;

    logic        beat;
    logic        frame_px;
    logic        restart;
    logic        start_ok;
    logic        at_limit;
    logic        word_full;
    logic        short_frame;
    logic [1:0]  lane_eff;
    logic [15:0] count_eff;
    logic [15:0] count_inc;
    logic [23:0] flush_mask;
    logic [3:0]  flush_be;

    assign snk.ready = (state == S_WAIT_SOP) || (state == S_CAPTURE);
    assign busy      = (state == S_WAIT_SOP) || (state == S_CAPTURE) || (state == S_FLUSH);
    assign beat      = snk.valid && snk.ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign restart   = beat && (state == S_CAPTURE) && snk.sop;
    // Pre-sop beats in WAIT_SOP are consumed but never become frame pixels.
    assign frame_px  = beat && ((state == S_CAPTURE) || snk.sop);

    // A frame's first pixel (fresh or restarted) always lands in lane 0 of word 0.
    assign lane_eff  = (restart || (state == S_WAIT_SOP)) ? 2'd0  : lane_q;
    assign count_eff = (restart || (state == S_WAIT_SOP)) ? 16'd0 : word_count;
    assign count_inc = count_eff + 16'd1;
    assign at_limit  = (count_eff == FW);
    assign word_full = (lane_eff == 2'd3);
    // Either a full or a partial final word adds one write unless the frame is already full.
    assign short_frame = (at_limit ? count_eff : count_inc) < FW;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        flush_mask = 24'h0000FF;
        flush_be   = 4'b0001;
        unique case (lane_q)
            2'd2:    begin flush_mask = 24'h00FFFF; flush_be = 4'b0011; end
            2'd3:    begin flush_mask = 24'hFFFFFF; flush_be = 4'b0111; end
            default: begin flush_mask = 24'h0000FF; flush_be = 4'b0001; end
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (start_ok) state_nx = S_WAIT_SOP;
            S_WAIT_SOP: if (frame_px) state_nx = snk.eop ? S_FLUSH : S_CAPTURE;
            S_CAPTURE:  if (frame_px && snk.eop) state_nx = S_FLUSH;
            S_FLUSH:    state_nx = S_DONE;
            S_DONE:     if (start_ok) state_nx = S_WAIT_SOP;
            default:    state_nx = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done           <= 1'b0;
            err            <= 1'b0;
            word_count     <= 16'd0;
            lane_q         <= 2'd0;
            pack_q         <= 24'd0;
            flush_q        <= 1'b0;
            mem.address    <= 16'd0;
            mem.byteenable <= 4'b0000;
            mem.chipselect <= 1'b0;
            mem.write      <= 1'b0;
            mem.writedata  <= 32'd0;
            mem.clken      <= 1'b0;
        end else begin
            mem.clken      <= 1'b1;
            mem.chipselect <= 1'b0;
            mem.write      <= 1'b0;

            if (start_ok) begin
                done       <= 1'b0;
                err        <= 1'b0;
                word_count <= 16'd0;
                lane_q     <= 2'd0;
                flush_q    <= 1'b0;
            end

            if (frame_px) begin
                case (lane_eff)
                    2'd0:    pack_q[7:0]   <= snk.data;
                    2'd1:    pack_q[15:8]  <= snk.data;
                    2'd2:    pack_q[23:16] <= snk.data;
                    default: ;
                endcase
                lane_q     <= lane_eff + 2'd1;
                word_count <= count_eff;

                if (word_full && !at_limit) begin
                    mem.chipselect <= 1'b1;
                    mem.write      <= 1'b1;
                    mem.address    <= base_cur + count_eff;
                    mem.byteenable <= 4'b1111;
                    mem.writedata  <= {snk.data, pack_q};
                    word_count     <= count_inc;
                end

                // Pixels past a full buffer are swallowed; a mid-frame sop drops the partial word.
                if (restart || at_limit) err <= 1'b1;

                if (snk.eop) begin
                    flush_q <= !word_full && !at_limit;
                    if (short_frame) err <= 1'b1;
                end
            end

            if (state == S_FLUSH) begin
                done <= 1'b1;
                if (flush_q) begin
                    mem.chipselect <= 1'b1;
                    mem.write      <= 1'b1;
                    mem.address    <= base_cur + word_count;
                    mem.byteenable <= flush_be;
                    mem.writedata  <= {8'h00, pack_q & flush_mask};
                    word_count     <= word_count + 16'd1;
                end
            end
        end
    end

`ifdef FRAME_WRITER_DBL_BUF_EN
    logic wr_buf_q;    // buffer the frame in progress is written to

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_buf_q <= 1'b0;
            buf_sel  <= 1'b0;
        end else if (state == S_FLUSH) begin
            buf_sel  <= wr_buf_q;
            wr_buf_q <= ~wr_buf_q;
        end
    end

    assign base_cur = wr_buf_q ? (BASE_ADDR + FW) : BASE_ADDR;
`else
    assign buf_sel  = 1'b0;
    assign base_cur = BASE_ADDR;
`endif

endmodule

// File: tb/tb_soc_system_frame_writer.sv
// Directed bench for soc_system_frame_writer: a frame-level write model feeds a scoreboard
// that is checked on every clock, plus literal checks on status timing and reset behaviour.
module tb_soc_system_frame_writer;
    localparam logic [15:0] BASE = 16'hFFFE;
    localparam int          FW   = 4;
`ifdef FRAME_WRITER_DBL_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic        buf_sel;
    logic [15:0] word_count;

    frame_st_if  snk ();
    frame_mem_if mem ();

    soc_system_frame_writer #(
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .buf_sel    (buf_sel),
        .snk        (snk),
        .mem        (mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  got;
    int   checks = 0;
    int   errors = 0;
    logic model_bank = 1'b0;

    logic        e_err;
    logic        e_flush;
    logic [15:0] e_wc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        snk.valid = 1'b0;
        snk.sop   = 1'b0;
        snk.eop   = 1'b0;
        snk.data  = 8'h00;
        start     = 1'b0;
    endtask

    function automatic logic [7:0] px(input int i);
        return 8'(i + 1);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    // True when frame pixel i is the 4th pixel of a word that still fits in the buffer.
    function automatic bit wr_after(input int i, input int rs);
        int s = (rs > 0 && i >= rs) ? rs : 0;
        int k = i - s;
        return ((k % 4) == 3) && ((k / 4) < FW);
    endfunction

    function automatic logic [15:0] cur_base();
        return (DBL && model_bank) ? BASE + 16'(FW) : BASE;
    endfunction

    // Expected writes and status for n frame pixels; rs > 0 places a second sop at pixel rs.
    task automatic model_frame(input int n, input int rs,
                               output logic o_err, output logic [15:0] o_wc, output logic o_flush);
        int   starts[2];
        int   lens[2];
        int   nseg, full, part, nw, lanes, words;
        wr_t  w;
        logic [15:0] base = cur_base();
        o_err = 1'b0; o_wc = 16'd0; o_flush = 1'b0;
        if (rs > 0) begin
            nseg = 2; starts[0] = 0; lens[0] = rs; starts[1] = rs; lens[1] = n - rs; o_err = 1'b1;
        end else begin
            nseg = 1; starts[0] = 0; lens[0] = n; starts[1] = 0; lens[1] = 0;
        end
        for (int s = 0; s < nseg; s++) begin
            full  = lens[s] / 4;
            part  = lens[s] % 4;
            nw    = (full < FW) ? full : FW;
            words = nw + (((s == nseg - 1) && part != 0 && full < FW) ? 1 : 0);
            for (int wi = 0; wi < words; wi++) begin
                lanes  = (wi < full) ? 4 : part;
                w.addr = base + 16'(wi);
                w.data = 32'd0;
                w.be   = 4'b0000;
                for (int k = 0; k < lanes; k++) begin
                    w.data[8*k +: 8] = px(starts[s] + 4*wi + k);
                    w.be[k]          = 1'b1;
                end
                exp_q.push_back(w);
            end
            if (lens[s] > 4*FW) o_err = 1'b1;
            if (s == nseg - 1) begin
                o_flush = (part != 0) && (full < FW);
                o_wc    = 16'(((full + (part != 0 ? 1 : 0)) < FW) ? full + (part != 0 ? 1 : 0) : FW);
                if (o_wc < 16'(FW)) o_err = 1'b1;
            end
        end
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_done_clr", done, 1'b0);
        check("start_err_clr", err, 1'b0);
        check("start_ready", snk.ready, 1'b1);
    endtask

    task automatic drive_frame(input int n, input int rs, input int junk, input bit start_mid,
                               input logic x_err, input logic [15:0] x_wc, input logic x_flush);
        for (int j = 0; j < junk; j++) begin
            tick();
            check("ready_wait_sop", snk.ready, 1'b1);
            snk.valid = 1'b1; snk.sop = 1'b0; snk.eop = 1'b0; snk.data = 8'hEE;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            check("ready_in_frame", snk.ready, 1'b1);
            check("wr_strobe_timing", mem.write, (i > 0) ? wr_after(i - 1, rs) : 1'b0);
            snk.valid = 1'b1;
            snk.data  = px(i);
            snk.sop   = (i == 0) || (rs > 0 && i == rs);
            snk.eop   = (i == n - 1);
            start     = start_mid && (i == 2);
        end
        tick();
        idle_inputs();
        check("flush_busy", busy, 1'b1);
        check("flush_done", done, 1'b0);
        check("flush_ready", snk.ready, 1'b0);
        check("wr_strobe_timing", mem.write, wr_after(n - 1, rs));
        tick();
        check("done_set", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_ready", snk.ready, 1'b0);
        check("done_err", err, x_err);
        check("done_word_count", word_count, x_wc);
        check("flush_write", mem.write, x_flush);
        check("buf_sel", buf_sel, DBL ? model_bank : 1'b0);
        model_bank = ~model_bank;
        tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Scoreboard: every write strobe must match the next modelled write.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_write", mem.write, 1'b0);
                check("reset_clken", mem.clken, 1'b0);
            end else begin
                check("clken", mem.clken, 1'b1);
                if (mem.write === 1'b1) begin
                    check("wr_chipselect", mem.chipselect, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %h data %h be %b, no write required",
                                 mem.address, mem.writedata, mem.byteenable);
                    end else begin
                        got = exp_q.pop_front();
                        check("wr_addr", mem.address, got.addr);
                        check("wr_be", mem.byteenable, got.be);
                        check("wr_data", mem.writedata & lane_mask(got.be), got.data & lane_mask(got.be));
                    end
                end
            end
        end
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_clken", mem.clken, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        check("init_busy", busy, 1'b0);
        check("init_done", done, 1'b0);
        check("init_err", err, 1'b0);
        check("init_ready", snk.ready, 1'b0);
        check("init_word_count", word_count, 16'd0);
        check("init_write", mem.write, 1'b0);
        check("init_cs", mem.chipselect, 1'b0);
        check("init_addr", mem.address, 16'd0);
        check("init_data", mem.writedata, 32'd0);
        check("init_be", mem.byteenable, 4'b0000);
        check("init_buf_sel", buf_sel, 1'b0);
        check("init_clken", mem.clken, 1'b1);

        // Pixels offered before start must not be taken.
        for (int i = 0; i < 3; i++) begin
            snk.valid = 1'b1; snk.sop = 1'b1; snk.data = 8'h55;
            tick();
            check("gate_ready", snk.ready, 1'b0);
            check("gate_busy", busy, 1'b0);
        end
        idle_inputs();

        // Nominal frame, addresses wrap past 16'hFFFF.
        do_start();
        model_frame(16, 0, e_err, e_wc, e_flush);
        check("pin_nom_w0_addr", exp_q[0].addr, 16'hFFFE);
        check("pin_nom_w0_data", exp_q[0].data, 32'h04030201);
        check("pin_nom_w2_addr", exp_q[2].addr, 16'h0000);
        check("pin_nom_w3_data", exp_q[3].data, 32'h100F0E0D);
        check("pin_nom_err", e_err, 1'b0);
        drive_frame(16, 0, 0, 1'b0, e_err, e_wc, e_flush);

        // Short frame with a 2-pixel flush word, preceded by discarded pre-sop beats.
        do_start();
        model_frame(10, 0, e_err, e_wc, e_flush);
        check("pin_part_size", exp_q.size(), 3);
        check("pin_part_be", exp_q[2].be, 4'b0011);
        check("pin_part_data", exp_q[2].data[15:0], 16'h0A09);
        check("pin_part_wc", e_wc, 16'd3);
        drive_frame(10, 0, 3, 1'b0, e_err, e_wc, e_flush);

        // Overflow: 6 words offered into a 4-word buffer.
        do_start();
        model_frame(24, 0, e_err, e_wc, e_flush);
        check("pin_ovf_size", exp_q.size(), 4);
        check("pin_ovf_err", e_err, 1'b1);
        drive_frame(24, 0, 0, 1'b0, e_err, e_wc, e_flush);

        // Restart at pixel 6 with a start pulse while busy.
        do_start();
        model_frame(10, 6, e_err, e_wc, e_flush);
        check("pin_rst_size", exp_q.size(), 2);
        check("pin_rst_data", exp_q[1].data, 32'h0A090807);
        check("pin_rst_wc", e_wc, 16'd1);
        drive_frame(10, 6, 0, 1'b1, e_err, e_wc, e_flush);

        // Reset mid-frame while a write strobe is up.
        do_start();
        model_frame(4, 0, e_err, e_wc, e_flush);
        for (int i = 0; i < 4; i++) begin
            tick();
            snk.valid = 1'b1; snk.data = px(i); snk.sop = (i == 0); snk.eop = 1'b0;
        end
        tick();
        check("write_before_reset", mem.write, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_write", mem.write, 1'b0);
        check("mid_rst_cs", mem.chipselect, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", snk.ready, 1'b0);
        check("mid_rst_word_count", word_count, 16'd0);
        check("mid_rst_clken", mem.clken, 1'b0);
        check("mid_rst_addr", mem.address, 16'd0);
        check("mid_rst_data", mem.writedata, 32'd0);
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        model_bank = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);
        check("post_rst_queue", exp_q.size(), 0);

        // Recovery frame after reset starts again at buffer 0.
        do_start();
        model_frame(16, 0, e_err, e_wc, e_flush);
        check("pin_rec_w0_addr", exp_q[0].addr, 16'hFFFE);
        drive_frame(16, 0, 0, 1'b0, e_err, e_wc, e_flush);

        for (int i = 0; i < 3; i++) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
